ped_signal_controller: RTL and testbench
========================================

# ped_signal_controller

Pedestrian crossing stage downstream of the vehicle traffic-light controller. It consumes the one-hot `red`/`yellow`/`green` vehicle signals, latches pedestrian button requests, and grants a WALK then flashing-CLEAR interval aligned to the start of each vehicle red phase. Any illegal or premature change in the vehicle signals forces a latched safe FAULT state.

## Interface
- `WALK_CYCLES`, default 2: cycles of solid WALK, range 1..15.
- `CLEAR_CYCLES`, default 2: cycles of flashing don't-walk, range 1..15.
- `FLASH_PERIOD`, default 1: cycles per `dont_walk` toggle during CLEAR, range 1..15.
- `DEBOUNCE_CYCLES`, default 4: stable-high cycles required per press; used only with the debounce filter, range 1..15.
- `clk` input 1: single clock; every flop is on its rising edge.
- `reset` input 1: asynchronous, active-low; `reset` low clears all state immediately.
- `red`, `yellow`, `green` input 1 each: vehicle lights from the upstream controller; one-hot expected.
- `ped_button` input 1: raw pedestrian push-button, asynchronous to `clk`.
- `walk` output 1: WALK lamp.
- `dont_walk` output 1: DON'T WALK lamp; flashes during CLEAR.
- `countdown` output 4: remaining CLEAR cycles; 0 outside CLEAR.
- `req_pending` output 1: a request is latched and not yet served.
- `fault` output 1: sticky safety fault.

## Operation
- Reset values: state DONT_WALK, `walk`=0, `dont_walk`=1, `countdown`=0, `req_pending`=0, `fault`=0.
- Reset values for internal flops: `red_q`=1, so red already present after reset is not an edge. Synchronizer and debounce flops reset to 0.
- Button path: 2-flop synchronizer, then rising-edge detect, produces a one-cycle `press`. `press` sets `req_pending`.
- States: DONT_WALK, WALK, CLEAR, FAULT. Outputs are Moore-decoded from registered state.
- DONT_WALK:
  - When lights are legal, red rises (`red`=1, `red_q`=0) and `req_pending`=1: go to WALK, load counter with WALK_CYCLES-1, clear `req_pending`.
  - A request latched while red is already high waits for the next red rising edge.
- WALK: `walk`=1, `dont_walk`=0. Counter decrements each cycle. When the counter is 0: go to CLEAR, load counter with CLEAR_CYCLES-1, set the flash bit to 1.
- CLEAR:
  - `walk`=0 and `dont_walk` = flash bit; the flash bit toggles every FLASH_PERIOD cycles.
  - `countdown` = counter+1.
  - When the counter is 0: go to DONT_WALK.
- FAULT: `walk`=0, `dont_walk`=1, `fault`=1. Exited only by reset.
- Enter FAULT from any state on either condition:
  - Vehicle inputs not exactly one-hot for any sampled cycle.
  - `red` sampled 0 while in WALK or CLEAR.
- Simultaneous events:
  - `press` in the grant cycle is absorbed; `req_pending` ends 0.
  - `press` during WALK is ignored.
  - `press` during CLEAR sets `req_pending` for the next red.
  - FAULT takes priority over every other transition.
- Counter is 4 bits. The parameter ranges guarantee no wrap.

## Timing
- Red first sampled high at edge N: `walk` is high for cycles after edges N..N+WALK_CYCLES-1.
- CLEAR follows for CLEAR_CYCLES cycles, then DONT_WALK.
- Defaults use 4 cycles, which fits inside the upstream 5-cycle red.
- `ped_button` first sampled high at edge k: `req_pending` is high after edge k+2. The debounced variant gives k+1+DEBOUNCE_CYCLES.
- Reset assertion mid-WALK returns outputs to reset values immediately, with no clock required.

## Configuration
- Macro: `PED_DEBOUNCE_EN`.
- Defined: after the synchronizer, the level must stay high for DEBOUNCE_CYCLES consecutive cycles to emit one `press`. The level must return low for at least one cycle to re-arm. Glitches shorter than DEBOUNCE_CYCLES are dropped.
- Undefined: `press` is the plain edge of the synchronized level, and DEBOUNCE_CYCLES is unused.

## Structure
- Shared package `ped_pkg`: state enum `ped_state_t` (DONT_WALK, WALK, CLEAR, FAULT), 2-bit encoding, and the 4-bit counter width constant.
- Sub-module `ped_button_conditioner`: synchronizer, optional debounce and edge detect, producing `press`.
- The top level holds the FSM, counter, flash bit, `red_q` and the fault logic.

## Test plan
- Defaults, reset released with red high, button pulse during green → `req_pending`=1. At the next red rise, `walk`=1 for 2 cycles, then CLEAR with `dont_walk` 1,0 and `countdown` 2,1, then `dont_walk`=1 and `req_pending`=0.
- Red rises with `req_pending`=0 → `walk` stays 0 for the whole red phase.
- Press in the CLEAR cycle → `req_pending`=1 after that red ends, and WALK is granted at the following red rise.
- Force `red`=`green`=1 for one cycle mid-WALK → next cycle `walk`=0, `dont_walk`=1, `fault`=1, held until reset goes low.
- Red drops after 2 cycles with WALK_CYCLES=3 → FAULT.
- With `PED_DEBOUNCE_EN` defined: a 3-cycle button glitch → no request; a 4-cycle hold → exactly one request. Reset pulsed low mid-CLEAR → outputs return immediately to reset values.

Source files
------------

// File: rtl/ped_pkg.sv
// rtl/ped_pkg.sv - shared state encoding and counter width for the pedestrian crossing stage
package ped_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        DONT_WALK = 2'd0,
        WALK      = 2'd1,
        CLEAR     = 2'd2,
        FAULT     = 2'd3
    } ped_state_t;

endpackage

// File: rtl/ped_button_conditioner.sv
// rtl/ped_button_conditioner.sv - button synchronizer, optional debounce (PED_DEBOUNCE_EN), one-cycle press
module ped_button_conditioner
    import ped_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic ped_button,
    output logic press
);

    logic sync1;
    logic sync2;

    // two-flop synchronizer for the raw asynchronous button
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= ped_button;
            sync2 <= sync1;
        end
    end

`ifdef PED_DEBOUNCE_EN
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] high_cnt;
    logic             fired;

    // high_cnt holds how many earlier cycles the level has been high; fire on the last one
    assign press = sync2 && !fired && (high_cnt == DB_LAST);

    // count the stable-high run, fire once per hold and re-arm on any low cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            high_cnt <= '0;
            fired    <= 1'b0;
        end else if (!sync2) begin
            high_cnt <= '0;
            fired    <= 1'b0;
        end else if (press) begin
            fired    <= 1'b1;
        end else if (!fired && (high_cnt != DB_LAST)) begin
            high_cnt <= high_cnt + 4'd1;
        end
    end
`else
    logic level_q;
    logic unused_debounce_cfg;

    assign unused_debounce_cfg = ^CNT_W'(DEBOUNCE_CYCLES);
    assign press               = sync2 && !level_q;

    // previous synchronized level for rising-edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level_q <= 1'b0;
        end else begin
            level_q <= sync2;
        end
    end
`endif

endmodule

// File: rtl/ped_signal_controller.sv
// rtl/ped_signal_controller.sv - pedestrian WALK/CLEAR grant aligned to vehicle red, sticky fault (PED_DEBOUNCE_EN selects debounced button)
module ped_signal_controller
    import ped_pkg::*;
#(
    parameter int WALK_CYCLES     = 2,
    parameter int CLEAR_CYCLES    = 2,
    parameter int FLASH_PERIOD    = 1,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       red,
    input  logic       yellow,
    input  logic       green,
    input  logic       ped_button,
    output logic       walk,
    output logic       dont_walk,
    output logic [3:0] countdown,
    output logic       req_pending,
    output logic       fault
);

    localparam logic [CNT_W-1:0] WALK_LOAD  = CNT_W'(WALK_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_CYCLES - 1);
    localparam logic [CNT_W-1:0] FLASH_LOAD = CNT_W'(FLASH_PERIOD - 1);

    ped_state_t       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] flash_cnt, flash_cnt_n;
    logic             flash, flash_n;
    logic             req_q, req_n;
    logic             red_q;
    logic             press;
    logic             lights_legal;
    logic             red_rise;
    logic             unsafe;

    ped_button_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_button (
        .clk       (clk),
        .reset     (reset),
        .ped_button(ped_button),
        .press     (press)
    );

    assign lights_legal = (red & ~yellow & ~green) | (~red & yellow & ~green) | (~red & ~yellow & green);
    assign red_rise     = red & ~red_q;
    assign unsafe       = !lights_legal || (((state == WALK) || (state == CLEAR)) && !red);

    // registered state; red_q resets high so a red already present at reset is not an edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= DONT_WALK;
            cnt       <= '0;
            flash_cnt <= '0;
            flash     <= 1'b1;
            req_q     <= 1'b0;
            red_q     <= 1'b1;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            flash_cnt <= flash_cnt_n;
            flash     <= flash_n;
            req_q     <= req_n;
            red_q     <= red;
        end
    end

    // next-state, counters and request latch; an unsafe light pattern overrides everything
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        flash_cnt_n = flash_cnt;
        flash_n     = flash;
        req_n       = req_q | press;
        case (state)
            DONT_WALK: begin
                if (red_rise && req_q) begin
                    state_n = WALK;
                    cnt_n   = WALK_LOAD;
                    req_n   = 1'b0;
                end
            end
            WALK: begin
                req_n = req_q;
                if (cnt == '0) begin
                    state_n     = CLEAR;
                    cnt_n       = CLEAR_LOAD;
                    flash_n     = 1'b1;
                    flash_cnt_n = FLASH_LOAD;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            CLEAR: begin
                if (flash_cnt == '0) begin
                    flash_n     = ~flash;
                    flash_cnt_n = FLASH_LOAD;
                end else begin
                    flash_cnt_n = flash_cnt - 4'd1;
                end
                if (cnt == '0) begin
                    state_n = DONT_WALK;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            default: begin
                state_n = FAULT;
            end
        endcase
        if (unsafe) begin
            state_n = FAULT;
            cnt_n   = '0;
            req_n   = req_q | press;
        end
    end

    // Moore output decode from the registered state
    always_comb begin
        walk        = 1'b0;
        dont_walk   = 1'b1;
        countdown   = 4'd0;
        fault       = 1'b0;
        req_pending = req_q;
        case (state)
            WALK: begin
                walk      = 1'b1;
                dont_walk = 1'b0;
            end
            CLEAR: begin
                dont_walk = flash;
                countdown = cnt + 4'd1;
            end
            FAULT: begin
                fault = 1'b1;
            end
            default: begin
                dont_walk = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_ped_signal_controller.sv
// tb/tb_ped_signal_controller.sv - self-checking bench for ped_signal_controller
module tb_ped_signal_controller;

    localparam int W  = 2;
    localparam int C  = 2;
    localparam int FP = 1;
    localparam int DB = 4;
`ifdef PED_DEBOUNCE_EN
    localparam int DM = DB;
`else
    localparam int DM = 1;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       red = 1'b1;
    logic       yellow = 1'b0;
    logic       green = 1'b0;
    logic       ped_button = 1'b0;
    logic       walk, dont_walk, req_pending, fault;
    logic [3:0] countdown;
    logic       walk3, dont_walk3, req3, fault3;
    logic [3:0] countdown3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ped_signal_controller #(
        .WALK_CYCLES(W), .CLEAR_CYCLES(C), .FLASH_PERIOD(FP), .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk(clk), .reset(reset), .red(red), .yellow(yellow), .green(green),
        .ped_button(ped_button), .walk(walk), .dont_walk(dont_walk),
        .countdown(countdown), .req_pending(req_pending), .fault(fault)
    );

    ped_signal_controller #(
        .WALK_CYCLES(3), .CLEAR_CYCLES(C), .FLASH_PERIOD(FP), .DEBOUNCE_CYCLES(DB)
    ) dut3 (
        .clk(clk), .reset(reset), .red(red), .yellow(yellow), .green(green),
        .ped_button(ped_button), .walk(walk3), .dont_walk(dont_walk3),
        .countdown(countdown3), .req_pending(req3), .fault(fault3)
    );

    task automatic chk(input string name, input logic [7:0] act, input int exp);
        checks++;
        if (act !== exp[7:0]) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a grant is an interval measured in edges from the grant edge
    bit m_fault, m_busy, m_req, m_prev_red;
    int m_off;
    bit bh [0:23];

    always @(posedge clk or negedge reset) begin
        bit p;
        bit bad;
        int ones;
        if (!reset) begin
            m_fault    = 1'b0;
            m_busy     = 1'b0;
            m_req      = 1'b0;
            m_prev_red = 1'b1;
            m_off      = 0;
            for (int i = 0; i < 24; i++) bh[i] = 1'b0;
        end else begin
            for (int i = 23; i > 0; i--) bh[i] = bh[i-1];
            bh[0] = ped_button;
            // a press lands DM+1 edges after the first of DM consecutive high samples
            p = !bh[DM+2];
            for (int i = 2; i <= DM + 1; i++) if (!bh[i]) p = 1'b0;
            ones = int'(red) + int'(yellow) + int'(green);
            bad  = (ones != 1) || (m_busy && !red);
            if (m_fault) begin
                m_fault = 1'b1;
            end else if (bad) begin
                m_fault = 1'b1;
                m_busy  = 1'b0;
            end else if (m_busy) begin
                if (p && m_off >= W) m_req = 1'b1;
                m_off++;
                if (m_off == W + C) m_busy = 1'b0;
            end else if (red && !m_prev_red && m_req) begin
                m_busy = 1'b1;
                m_off  = 0;
                m_req  = 1'b0;
            end else if (p) begin
                m_req = 1'b1;
            end
            m_prev_red = red;
        end
    end

    // Every-cycle comparison against the model, just after the active edge
    always @(posedge clk) begin
        int ew, edw, ecd, ef, j;
        #1;
        ew = 0; edw = 1; ecd = 0; ef = 0;
        if (m_fault) begin
            ef = 1;
        end else if (m_busy && m_off < W) begin
            ew = 1; edw = 0;
        end else if (m_busy) begin
            j   = m_off - W;
            edw = ((j / FP) % 2 == 0) ? 1 : 0;
            ecd = C - j;
        end
        chk("model_walk", walk, ew);
        chk("model_dont_walk", dont_walk, edw);
        chk("model_countdown", countdown, ecd);
        chk("model_fault", fault, ef);
        if (!m_fault) chk("model_req", req_pending, int'(m_req));
    end

    task automatic cyc(input bit r, input bit y, input bit g, input bit b);
        red = r; yellow = y; green = g; ped_button = b;
        @(negedge clk);
    endtask

    task automatic green_press();
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b1, i < 5);
        repeat (2) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_walk", walk, 0);
        chk("rst_dont_walk", dont_walk, 1);
        chk("rst_countdown", countdown, 0);
        chk("rst_req", req_pending, 0);
        chk("rst_fault", fault, 0);
        reset = 1'b1;
        repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0);

        // request during green, granted at next red rise
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b1, i < 5);
        chk("t1_req_latched", req_pending, 1);
        repeat (2) cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0); chk("t1_walk_a", walk, 1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0); chk("t1_walk_b", walk, 1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("t1_clr0_walk", walk, 0); chk("t1_clr0_dw", dont_walk, 1); chk("t1_clr0_cd", countdown, 2);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("t1_clr1_dw", dont_walk, 0); chk("t1_clr1_cd", countdown, 1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("t1_end_dw", dont_walk, 1); chk("t1_end_cd", countdown, 0); chk("t1_end_req", req_pending, 0);

        // red with no request: no walk at all
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (2) cyc(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            chk("t2_no_walk", walk, 0);
        end

        // press landing in the first CLEAR cycle carries over to the next red
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b1, i < 5);
        for (int i = -3; i < 5; i++) cyc(i >= 0, i < 0, 1'b0, (i >= 2 - DM) && (i <= 1));
        chk("t3_req_after_red", req_pending, 1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (2) cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0); chk("t3_grant", walk, 1);
        repeat (4) cyc(1'b1, 1'b0, 1'b0, 1'b0);

        // illegal red+green mid-WALK: sticky fault until reset
        green_press();
        cyc(1'b1, 1'b0, 1'b0, 1'b0); chk("t4_walk", walk, 1);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        chk("t4_fault", fault, 1); chk("t4_walk_off", walk, 0); chk("t4_dw", dont_walk, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0);
            chk("t4_fault_held", fault, 1);
        end
        reset = 1'b0;
        @(negedge clk);
        chk("t4_fault_cleared", fault, 0);
        reset = 1'b1;
        repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0);

        // WALK_CYCLES=3 instance: red dropping after two cycles is a fault
        green_press();
        cyc(1'b1, 1'b0, 1'b0, 1'b0); chk("t5_walk_a", walk3, 1); chk("t5_req", req3, 0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0); chk("t5_walk_b", walk3, 1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("t5_fault", fault3, 1); chk("t5_walk_off", walk3, 0);
        chk("t5_dw", dont_walk3, 1); chk("t5_cd", countdown3, 0);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0);

        // short glitch versus full-length hold
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b1, i < 3);
`ifdef PED_DEBOUNCE_EN
        chk("t6_glitch_dropped", req_pending, 0);
`else
        chk("t6_glitch_edge", req_pending, 1);
`endif
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b1, i < 4);
        chk("t6_hold_request", req_pending, 1);
        repeat (2) cyc(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (5) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("t6_single_request", req_pending, 0);

        // asynchronous reset in the middle of CLEAR
        green_press();
        repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("t7_in_clear", countdown, 2);
        #2 reset = 1'b0;
        #1;
        chk("t7_walk", walk, 0);
        chk("t7_dw", dont_walk, 1);
        chk("t7_cd", countdown, 0);
        chk("t7_req", req_pending, 0);
        chk("t7_fault", fault, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, 1'b0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
